// File: rtl/pollard_pkg.sv
// Shared definitions for the Pollard p-1 datapath: default operand width,
// GCD controller states and the worst-case start-to-done latency.
package pollard_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int LAT_MAX   = 4 * DEF_WIDTH + 4;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      TWOS,
      ODDU,
      LOOP,
      FINISH
   } state_t;

endpackage

// File: rtl/pollard_gcd_unit.sv
// Binary (Stein) GCD of (a^M - 1 mod n, n), reporting whether the result is a
// nontrivial factor of n. One shift or swap/subtract step per cycle.
module pollard_gcd_unit
   import pollard_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int KW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] residue,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out,
   output logic             factor_found
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] u_q, u_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             ff_q, ff_d;
   logic [WIDTH-1:0] g;

   // Every path into FINISH leaves the odd part in u and the shared twos in k.
   assign g = u_q << k_q;

   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      v_d     = v_q;
      k_d     = k_q;
      mod_d   = mod_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      gcd_d   = gcd_q;
      ff_d    = ff_q;
      case (state_q)
         IDLE: begin
            // The controller is already back in IDLE during the done cycle;
            // a start there must not be taken.
            if (done_q) begin
               busy_d = 1'b0;
            end else if (start) begin
               u_d     = (residue == '0) ? modulus - WIDTH'(1) : residue - WIDTH'(1);
               v_d     = modulus;
               k_d     = '0;
               mod_d   = modulus;
               busy_d  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (mod_q < WIDTH'(2)) begin
               u_d     = '0;
               k_d     = '0;
               state_d = FINISH;
            end else if (u_q == '0) begin
               u_d     = v_q;
               state_d = FINISH;
            end else begin
               state_d = TWOS;
            end
         end
         TWOS: begin
            if (!u_q[0] && !v_q[0]) begin
               u_d = u_q >> 1;
               v_d = v_q >> 1;
               k_d = k_q + KW'(1);
            end else begin
               state_d = ODDU;
            end
         end
         ODDU: begin
            if (!u_q[0]) u_d = u_q >> 1;
            else         state_d = LOOP;
         end
         LOOP: begin
            // u stays odd here, so the difference of two odds is always even.
            if (v_q == '0) begin
               state_d = FINISH;
            end else if (!v_q[0]) begin
               v_d = v_q >> 1;
            end else if (u_q < v_q) begin
               v_d = v_q - u_q;
            end else begin
               u_d = v_q;
               v_d = u_q - v_q;
            end
         end
         FINISH: begin
            gcd_d   = g;
            ff_d    = (g > WIDTH'(1)) && (g < mod_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         u_q     <= '0;
         v_q     <= '0;
         k_q     <= '0;
         mod_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gcd_q   <= '0;
         ff_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         k_q     <= k_d;
         mod_q   <= mod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gcd_q   <= gcd_d;
         ff_q    <= ff_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign gcd_out      = gcd_q;
   assign factor_found = ff_q;

endmodule

// File: tb/tb_pollard_gcd_unit.sv
// Directed and random checks of pollard_gcd_unit against a Euclid-based model.
module tb_pollard_gcd_unit;
   import pollard_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] residue, modulus;
   logic        busy, done, factor_found;
   logic [31:0] gcd_out;

   int total = 0;
   int bad   = 0;

   pollard_gcd_unit dut (
      .clk(clk), .rst(rst), .start(start), .residue(residue), .modulus(modulus),
      .busy(busy), .done(done), .gcd_out(gcd_out), .factor_found(factor_found)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // gcd(x, n) with x = residue-1 (or n-1 for residue 0), by Euclid's remainders.
   function automatic void ref_gcd(input logic [31:0] r, input logic [31:0] m,
                                   output logic [31:0] g, output logic f);
      logic [31:0] a, b, t;
      if (m < 2) begin
         g = 0; f = 0;
         return;
      end
      a = (r == 0) ? m - 1 : r - 1;
      b = m;
      while (b != 0) begin
         t = a % b; a = b; b = t;
      end
      g = a;
      f = (g > 1) && (g < m);
   endfunction

   task automatic run(input logic [31:0] r, input logic [31:0] m,
                      output logic [31:0] g, output logic f, output int lat,
                      output logic seen, output logic busy_at_done);
      @(negedge clk);
      start = 1'b1; residue = r; modulus = m;
      @(negedge clk);
      start = 1'b0; residue = $urandom; modulus = $urandom;
      lat = 1; seen = 1'b0; busy_at_done = 1'b0;
      while (lat <= LAT_MAX) begin
         if (done) begin
            seen = 1'b1; busy_at_done = busy;
            break;
         end
         @(negedge clk);
         lat++;
      end
      g = gcd_out; f = factor_found;
   endtask

   task automatic check_case(input string tag, input logic [31:0] r, input logic [31:0] m);
      logic [31:0] eg, gg;
      logic        ef, gf, seen, bd;
      int          lat;
      ref_gcd(r, m, eg, ef);
      run(r, m, gg, gf, lat, seen, bd);
      chk({tag, "_done"}, 32'(seen), 1);
      chk({tag, "_gcd"}, gg, eg);
      chk({tag, "_ff"}, 32'(gf), 32'(ef));
      chk({tag, "_busy_at_done"}, 32'(bd), 1);
      chk({tag, "_lat_ok"}, 32'(lat <= LAT_MAX), 1);
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 0);
      chk({tag, "_done_pulse"}, 32'(done), 0);
   endtask

   initial begin
      logic [31:0] g, m, r;
      logic        f, seen, bd;
      int          lat, pulses, n;

      rst = 1'b1; start = 1'b0; residue = '0; modulus = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_gcd", gcd_out, 0);
      chk("rst_ff", 32'(factor_found), 0);
      rst = 1'b0;

      check_case("r6_m15", 6, 15);
      chk("r6_m15_val", gcd_out, 5);
      chk("r6_m15_ffval", 32'(factor_found), 1);

      run(1, 15, g, f, lat, seen, bd);
      chk("r1_gcd", g, 15);
      chk("r1_ff", 32'(f), 0);
      chk("r1_lat", 32'(lat), 3);

      check_case("r0_m15", 0, 15);
      chk("r0_val", gcd_out, 1);
      check_case("r179_m8633", 179, 8633);
      chk("r179_val", gcd_out, 89);
      check_case("r9_m12", 9, 12);
      chk("r9_val", gcd_out, 4);
      check_case("m1", 5, 1);
      chk("m1_val", gcd_out, 0);
      check_case("m0", 3, 0);
      check_case("r_gt_m", 100, 33);
      check_case("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      // Start held high through the run with different operands on the bus.
      @(negedge clk);
      start = 1'b1; residue = 6; modulus = 15;
      @(negedge clk);
      residue = 179; modulus = 8633;
      pulses = 0; g = '0;
      for (n = 0; n < LAT_MAX + 20; n++) begin
         if (done) begin
            pulses++; g = gcd_out;
         end else if (pulses > 0) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_ign_pulses", 32'(pulses), 1);
      chk("busy_ign_gcd", g, 5);
      chk("busy_ign_idle", 32'(busy), 0);

      // Abort mid-LOOP; gcd_out currently holds a nonzero value.
      check_case("pre_rst", 6, 15);
      @(negedge clk);
      start = 1'b1; residue = 179; modulus = 8633;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_gcd", gcd_out, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (LAT_MAX) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 0);
      check_case("post_rst", 6, 15);
      chk("post_rst_val", gcd_out, 5);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: m = $urandom_range(0, 40);
            1: m = $urandom_range(2, 2000) * $urandom_range(2, 2000);
            default: m = $urandom;
         endcase
         r = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 64);
         check_case("rand", r, m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pollard_gcd_unit.md
Name: pollard_gcd_unit

Overview:
Consumer-side stage of the Pollard p-1 datapath. It takes the 32-bit residue a^M mod n produced by the modular-exponentiation block and computes g = gcd(a^M - 1 mod n, n) with a sequential binary (Stein) GCD. It reports whether g is a nontrivial factor of n. Control is a start/busy/done handshake, so the exponentiator's result can be handed over once it is valid.

Parameters:
WIDTH, 32, operand and result width in bits; matches the exponentiator's result width.
KW, $clog2(WIDTH)+1, width of the common-power-of-two counter k.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
residue  input  WIDTH  a^M mod n from the exponentiator; sampled with start.
modulus  input  WIDTH  n; sampled with start.
busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
done  output  1  one-cycle pulse when gcd_out and factor_found are valid.
gcd_out  output  WIDTH  g; held from done until the next accepted start.
factor_found  output  1  1 iff 1 < g < modulus; held with gcd_out.

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, gcd_out=0, factor_found=0; u, v and k cleared.
- Accept: in IDLE with start=1, load u <= (residue==0) ? modulus-1 : residue-1, v <= modulus, k <= 0. Go to CHECK.
- start outside IDLE is ignored, including in the done cycle.
- residue >= modulus is legal. The result is still gcd(residue-1, modulus), since gcd is invariant mod n. Do not reduce residue.
- modulus < 2: go from CHECK directly to FINISH with gcd_out=0 and factor_found=0.
- CHECK:
  - u==0 -> g=v, go to FINISH.
  - Otherwise -> TWOS.
  - The modulus < 2 rule above also applies here.
- TWOS: while u[0]==0 and v[0]==0, shift u and v right by 1 and increment k (one step per cycle). Otherwise go to ODDU.
- ODDU: while u[0]==0, u >>= 1. Otherwise go to LOOP.
- LOOP: one action per cycle, in priority order:
  - v==0 -> g = u << k, go to FINISH.
  - v[0]==0 -> v >>= 1.
  - Otherwise: u <= min(u,v), v <= max(u,v) - min(u,v). Swap and subtract happen in the same cycle; unsigned WIDTH-bit compare and subtract, with no borrow possible.
- FINISH: register gcd_out=g and factor_found = (g>1 && g<modulus_latched). Pulse done=1 for one cycle, then return to IDLE. busy drops in the cycle after done.
- Latency: accepted start to done is at most 4*WIDTH+4 cycles. Minimum is 3 cycles (residue==1 path).
- Reset asserted mid-operation aborts immediately: no done pulse, and outputs return to reset values.
- modulus is latched at accept; input changes during busy have no effect.

Decomposition:
- Package pollard_pkg holds:
  - the WIDTH default (shared with the exponentiator);
  - the state enum IDLE/CHECK/TWOS/ODDU/LOOP/FINISH;
  - the maximum-latency constant 4*WIDTH+4 for bench timeouts.
- Implement as a single module. The datapath (u, v, k, compare/subtract) is small enough that a sub-module adds no value.

Test Plan:
- residue=6, modulus=15 -> done within limit; gcd_out=5, factor_found=1.
- residue=1, modulus=15 (x=0) -> gcd_out=15, factor_found=0. Done 3 cycles after start.
- residue=0, modulus=15 (x=14) -> gcd_out=1, factor_found=0. Then residue=179, modulus=8633 (89*97) -> gcd_out=89, factor_found=1.
- residue=9, modulus=12 (x=8) -> exercises TWOS with k=2; gcd_out=4, factor_found=1. Also modulus=1 -> gcd_out=0, factor_found=0.
- Second start pulsed while busy, and residue/modulus changed mid-run -> ignored; first result unchanged; exactly one done pulse.
- rst asserted mid-LOOP -> busy=0, done never pulses, gcd_out=0. A subsequent start (residue=6, modulus=15) completes normally with 5.
